array_output_arbiter: RTL



---
 rtl/systola_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/array_output_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// Shared definitions for the systolic-array output path.
//
// Contents:
//   DEF_COLS / DEF_ROWS / DEF_OUTWIDTH  default array geometry and result width
//   COL_W / ROW_W                       index widths derived from the defaults
//   res_beat_t                          one output beat: data, column tag, row tag, last flag
package systola_pkg;

  localparam int DEF_COLS     = 8;
  localparam int DEF_ROWS     = 8;
  localparam int DEF_OUTWIDTH = 32;

  localparam int COL_W = $clog2(DEF_COLS);
  localparam int ROW_W = $clog2(DEF_ROWS);

  typedef struct packed {
    logic [DEF_OUTWIDTH-1:0] data;
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic                    last;
  } res_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an explicit wrap, so N need not be a power of two.
//
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   req        request vector, already qualified by the caller
//   advance    a grant is being taken this cycle; pointer moves past the winner
//   clear      restart the search from index 0 (takes effect combinationally
//              for this cycle's search, and in the pointer register)
//   gnt        one-hot grant (all zeros when no request)
//   gnt_idx    binary index of the granted requester
module rr_arbiter #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic             clear,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;
  int               w_sum;

  // A clear in the same cycle means the search must already start at 0, so
  // a grant taken alongside the clear belongs to the fresh rotation.
  assign w_base = clear ? '0 : r_ptr;

  // NOTE: every signal written here gets a default at the top of the block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(w_base) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = IDX_W'(w_sum);
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt[w_cand]  = 1'b1;
        gnt_idx      = w_cand;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (clear) begin
      r_ptr <= '0;
    end
  end

endmodule

// File: rtl/array_output_arbiter.sv
// Merges the results of COLS column output controllers into one valid/ready
// stream. Columns with a buffered result are served round-robin; each served
// column gets a one-cycle read strobe and its head result is registered into
// the output stage with its column/row tags.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   col_r       head result of each column controller
//   col_v       column holds an unread result
//   col_rread   one-hot read strobe, combinational, only in a granting cycle
//   out_data    registered result
//   out_col     column the result came from
//   out_row     row index (per-column beat count within the tile)
//   out_last    beat is the final (ROWS*COLS-th) beat of the tile
//   out_valid   output register holds a beat
//   out_ready   downstream accepts the beat this cycle
//   tile_done   one-cycle pulse after the out_last beat is accepted
module array_output_arbiter
  import systola_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int OUTWIDTH = DEF_OUTWIDTH
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [COLS-1:0][OUTWIDTH-1:0]  col_r,
  input  logic [COLS-1:0]                col_v,
  output logic [COLS-1:0]                col_rread,
  output logic [OUTWIDTH-1:0]            out_data,
  output logic [$clog2(COLS)-1:0]        out_col,
  output logic [$clog2(ROWS)-1:0]        out_row,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           tile_done
);

  localparam int TOTAL  = ROWS * COLS;
  localparam int CI_W   = $clog2(COLS);
  localparam int RI_W   = $clog2(ROWS);
  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int BEAT_W = $clog2(TOTAL + 1);

  logic                 w_load_en;
  logic                 w_tile_end;
  logic                 w_grant;
  logic [COLS-1:0]      w_req;
  logic [COLS-1:0]      w_gnt;
  logic [CI_W-1:0]      w_gnt_idx;
  logic [CNT_W-1:0]     w_row_base;
  logic [BEAT_W-1:0]    w_beats_base;

  logic [CNT_W-1:0]     r_rowcnt [COLS];
  logic [BEAT_W-1:0]    r_beats;
  logic                 r_valid;
  logic                 r_done;
  res_beat_t            r_beat;

  // Accepting the last beat ends the tile; counters are treated as already
  // cleared in that cycle so a grant alongside it starts the next tile.
  assign w_tile_end = r_valid && out_ready && r_beat.last;

  // rstn is folded in so no read strobe escapes while the block is in reset.
  assign w_load_en  = rstn && (!r_valid || out_ready);

  always_comb begin
    w_req = '0;
    for (int c = 0; c < COLS; c++) begin
      w_req[c] = w_load_en && col_v[c] &&
                 (w_tile_end || (r_rowcnt[c] < CNT_W'(ROWS)));
    end
  end

  rr_arbiter #(.N(COLS)) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req     (w_req),
    .advance (w_grant),
    .clear   (w_tile_end),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_grant      = |w_gnt;
  assign w_row_base   = w_tile_end ? '0 : r_rowcnt[w_gnt_idx];
  assign w_beats_base = w_tile_end ? '0 : r_beats;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_beat  <= '0;
      r_beats <= '0;
      // NOTE: the row counters are a small flop array, not a RAM, so they
      // take the asynchronous reset like any other control state.
      for (int c = 0; c < COLS; c++) r_rowcnt[c] <= '0;
    end else begin
      r_done <= w_tile_end;

      if (w_grant) begin
        r_valid <= 1'b1;
        r_beat  <= '{data: col_r[w_gnt_idx],
                     col:  w_gnt_idx,
                     row:  w_row_base[RI_W-1:0],
                     last: (w_beats_base == BEAT_W'(TOTAL - 1))};
        r_beats <= w_beats_base + BEAT_W'(1);
      end else begin
        if (out_ready)  r_valid <= 1'b0;
        if (w_tile_end) r_beats <= '0;
      end

      for (int c = 0; c < COLS; c++) begin
        if (w_grant && (w_gnt_idx == CI_W'(c))) begin
          r_rowcnt[c] <= w_row_base + CNT_W'(1);
        end else if (w_tile_end) begin
          r_rowcnt[c] <= '0;
        end
      end
    end
  end

  assign col_rread = w_gnt;
  assign out_data  = r_beat.data;
  assign out_col   = r_beat.col;
  assign out_row   = r_beat.row;
  assign out_last  = r_beat.last;
  assign out_valid = r_valid;
  assign tile_done = r_done;

endmodule
